zapper_shot_fsm: RTL
====================

ZAPPER_SHOT_FSM -- requirements
Module: zapper_shot_fsm

Interface
REQ-001 Parameter BLANK_CYCLES, default 16, SHALL set the cycle count of the screen-blank window after a trigger pull (legal range 1..65535).
REQ-002 Parameter LOOK_CYCLES, default 32, SHALL set the cycle count of the sensor look window (legal range 1..65535).
REQ-003 Parameter HOLD_CYCLES, default 8, SHALL set how many cycles the shot/hit result is presented (legal range 1..65535).
REQ-004 Parameter DEBOUNCE_CYCLES, default 4, SHALL set the trigger debounce stability length (legal range 1..255).
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-low.
REQ-007 sensor  input  1  raw Zapper light sensor, active-high, asynchronous to clk.
REQ-008 trigger  input  1  raw Zapper trigger, active-low (0 = pulled), asynchronous to clk.
REQ-009 blank_req  output  1  request to the video stage to draw the blank/target frame.
REQ-010 busy  output  1  high whenever the FSM is not IDLE.
REQ-011 plyr_input  output  16  game status word: [0] shot, [1] hit, [2] busy, [7:3] zero, [15:8] shot_count.

Function
REQ-012 sensor SHALL pass through a two-flop synchronizer; the trigger SHALL be inverted, then pass through a two-flop synchronizer (trig_sync, 1 = pulled).
REQ-013 A pull event SHALL be a 0->1 transition of the conditioned trigger (trig_db, or trig_sync per REQ-027); it is acted on only in IDLE and ignored in all other states.
REQ-014 FSM states SHALL be IDLE=0, BLANK=1, LOOK=2, HOLD=3, in a 2-bit register with a 16-bit down-counter.
REQ-015 IDLE: on pull -> BLANK, counter loaded with BLANK_CYCLES-1; else remain.
REQ-016 BLANK: blank_req=1; counter decrements each cycle; sensor ignored; counter==0 -> LOOK with counter loaded with LOOK_CYCLES-1, so BLANK lasts exactly BLANK_CYCLES cycles.
REQ-017 LOOK: synchronized sensor==1 -> HOLD with hit flag set; else counter==0 -> HOLD with hit flag clear; else decrement. Sensor and timeout in the same cycle SHALL count as a hit.
REQ-018 On each entry to HOLD, counter SHALL load HOLD_CYCLES-1 and shot_count SHALL increment by 1, wrapping 255->0.
REQ-019 HOLD: plyr_input[0]=1, plyr_input[1]=hit flag; at counter==0 -> IDLE, hit flag cleared.
REQ-020 plyr_input[0] and [1] SHALL be 0 outside HOLD; busy and plyr_input[2] SHALL equal (state != IDLE); all outputs SHALL be registered or decoded from registered state only.
REQ-021 A trigger held through HOLD into IDLE SHALL NOT start a new shot; a fresh release-and-pull is required.
REQ-022 Latency: raw trigger edge to BLANK entry SHALL be 3 cycles without debounce, 3+DEBOUNCE_CYCLES with debounce.

Reset
REQ-023 Asserting rst low SHALL immediately force state=IDLE, counter=0, hit flag=0, shot_count=0, synchronizer and debounce flops to 0 (trigger flops to "released"), blank_req=0, busy=0, plyr_input=16'h0000.
REQ-024 Reset asserted mid-shot (any state) SHALL abort it without incrementing shot_count.
REQ-025 After rst deasserts, a trigger already held low SHALL NOT create a pull event until it is released and pulled again.

Configuration
REQ-026 With macro ZAP_DEBOUNCE_EN defined, trig_db SHALL change to the value of trig_sync only after trig_sync has differed from trig_db for DEBOUNCE_CYCLES consecutive cycles (8-bit counter, cleared on any agreement).
REQ-027 Without ZAP_DEBOUNCE_EN, the debouncer SHALL be absent and trig_sync SHALL be used directly for pull detection; DEBOUNCE_CYCLES is then unused.

Verification (bench params BLANK=4, LOOK=8, HOLD=3, DEBOUNCE=2)
REQ-028 Clean pull, sensor stays 0 -> blank_req high 4 cycles, LOOK 8 cycles, plyr_input=16'h0105 for 3 cycles, then 16'h0100, busy=0.
REQ-029 Pull, sensor=1 in 3rd LOOK cycle (after sync) -> HOLD entered next cycle, plyr_input=16'h0107 for 3 cycles; sensor=1 during BLANK alone -> no hit.
REQ-030 Trigger glitch low for 1 cycle with ZAP_DEBOUNCE_EN -> no BLANK entry; same glitch without macro -> shot sequence starts.
REQ-031 Trigger held low across 3 complete shots' worth of time -> exactly one shot; 256 separate pulls -> shot_count wraps to 8'h00.
REQ-032 rst low during LOOK -> all outputs 0 within same cycle, state IDLE, shot_count unchanged from 0; trigger held through reset release -> no shot until re-pull.
REQ-033 Sensor=1 exactly on final LOOK cycle -> hit reported (plyr_input[1]=1).

Source files
------------

// File: rtl/zapper_shot_fsm.sv
// Zapper light-gun shot sequencer: trigger pull -> blank frame -> sensor look -> result hold.
// Define ZAP_DEBOUNCE_EN to insert the trigger debouncer ahead of pull detection.
module zapper_shot_fsm #(
  parameter int unsigned BLANK_CYCLES    = 16,
  parameter int unsigned LOOK_CYCLES     = 32,
  parameter int unsigned HOLD_CYCLES     = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sensor,
  input  logic        trigger,
  output logic        blank_req,
  output logic        busy,
  output logic [15:0] plyr_input
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] LOOK  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [15:0] BLANK_LD = 16'(BLANK_CYCLES - 1);
  localparam logic [15:0] LOOK_LD  = 16'(LOOK_CYCLES - 1);
  localparam logic [15:0] HOLD_LD  = 16'(HOLD_CYCLES - 1);

  if (BLANK_CYCLES < 1 || BLANK_CYCLES > 65535) begin : g_bad_blank
    $error("BLANK_CYCLES out of range");
  end
  if (LOOK_CYCLES < 1 || LOOK_CYCLES > 65535) begin : g_bad_look
    $error("LOOK_CYCLES out of range");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535) begin : g_bad_hold
    $error("HOLD_CYCLES out of range");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_db
    $error("DEBOUNCE_CYCLES out of range");
  end

  logic        sens_s1_q, sens_s2_q;
  logic        trig_s1_q, trig_s2_q;
  logic [1:0]  rdy_q;
  logic        armed_q;
  logic        trig_prev_q;
  logic        trig_cond;
  logic        pull;

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        hit_q, hit_d;
  logic [7:0]  shots_q, shots_d;

  // Pulls are only honoured once a released trigger has been seen after reset,
  // so a trigger held through reset release cannot fire a shot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sens_s1_q   <= 1'b0;
      sens_s2_q   <= 1'b0;
      trig_s1_q   <= 1'b0;
      trig_s2_q   <= 1'b0;
      rdy_q       <= '0;
      armed_q     <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      sens_s1_q   <= sensor;
      sens_s2_q   <= sens_s1_q;
      trig_s1_q   <= ~trigger;
      trig_s2_q   <= trig_s1_q;
      rdy_q       <= {rdy_q[0], 1'b1};
      armed_q     <= armed_q | (rdy_q[1] & ~trig_s2_q);
      trig_prev_q <= trig_cond;
    end
  end

`ifdef ZAP_DEBOUNCE_EN
  logic       db_q, db_d;
  logic [7:0] dbc_q, dbc_d;

  always_comb begin
    db_d  = db_q;
    dbc_d = '0;
    if (trig_s2_q != db_q) begin
      if (dbc_q == 8'(DEBOUNCE_CYCLES - 1)) begin
        db_d = trig_s2_q;
      end else begin
        dbc_d = dbc_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_q  <= 1'b0;
      dbc_q <= '0;
    end else begin
      db_q  <= db_d;
      dbc_q <= dbc_d;
    end
  end

  assign trig_cond = db_q;
`else
  assign trig_cond = trig_s2_q;
`endif

  assign pull = trig_cond & ~trig_prev_q & armed_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    shots_d = shots_q;
    case (state_q)
      IDLE: begin
        if (pull) begin
          state_d = BLANK;
          cnt_d   = BLANK_LD;
        end
      end
      BLANK: begin
        if (cnt_q == '0) begin
          state_d = LOOK;
          cnt_d   = LOOK_LD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      LOOK: begin
        // Sensor wins over timeout when both land in the same cycle.
        if (sens_s2_q || cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
          hit_d   = sens_s2_q;
          shots_d = shots_q + 8'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          hit_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      shots_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      shots_q <= shots_d;
    end
  end

  assign blank_req  = (state_q == BLANK);
  assign busy       = (state_q != IDLE);
  assign plyr_input = {shots_q, 5'b00000, busy,
                       (state_q == HOLD) & hit_q, (state_q == HOLD)};

endmodule
